reg_file_2r1w: RTL and testbench

//   Operand register file feeding the ALU: two combinational read ports drive
//   ALU a_i/b_i, one synchronous write port takes the write-back result.

---
 rtl/reg_file_2r1w.sv | 87 ++++++++
 tb/tb_reg_file_2r1w.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_2r1w.sv
// rtl/reg_file_2r1w.sv - two-read/one-write operand register file with ALU status flags
// Register 0 reads as zero; same-cycle writes are forwarded to matching read ports.
module reg_file_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] ra1_i,
  input  logic [ADDR_W-1:0] ra2_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic              flag_we_i,
  input  logic              zf_i,
  input  logic              sign_i,
  output logic              zf_o,
  output logic              sign_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic              zf_q, zf_d;
  logic              sign_q, sign_d;
  logic              wr_en;
  logic              byp1, byp2;

  assign wr_en = we_i && (wa_i != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  always_comb begin
    zf_d   = zf_q;
    sign_d = sign_q;
    if (flag_we_i) begin
      zf_d   = zf_i;
      sign_d = sign_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      zf_q   <= 1'b0;
      sign_q <= 1'b0;
    end else begin
      zf_q   <= zf_d;
      sign_q <= sign_d;
    end
  end

  // Forwarding is suppressed during reset so every port reads zero while it is held.
  assign byp1 = wr_en && !rst_i && (ra1_i == wa_i);
  assign byp2 = wr_en && !rst_i && (ra2_i == wa_i);

  always_comb begin
    rd1_o = regs_q[ra1_i];
    if (ra1_i == '0) begin
      rd1_o = '0;
    end else if (byp1) begin
      rd1_o = wd_i;
    end
  end

  always_comb begin
    rd2_o = regs_q[ra2_i];
    if (ra2_i == '0) begin
      rd2_o = '0;
    end else if (byp2) begin
      rd2_o = wd_i;
    end
  end

  assign zf_o   = zf_q;
  assign sign_o = sign_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb/tb_reg_file_2r1w.sv - scoreboard testbench for reg_file_2r1w
module tb_reg_file_2r1w;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  ra1_i, ra2_i, wa_i;
  logic [31:0] rd1_o, rd2_o, wd_i;
  logic        we_i, flag_we_i, zf_i, sign_i, zf_o, sign_o;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q [$];
  logic [31:0] model [32];
  logic [31:0] e;

  reg_file_2r1w #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ra1_i(ra1_i), .ra2_i(ra2_i), .rd1_o(rd1_o), .rd2_o(rd2_o),
    .we_i(we_i), .wa_i(wa_i), .wd_i(wd_i),
    .flag_we_i(flag_we_i), .zf_i(zf_i), .sign_i(sign_i),
    .zf_o(zf_o), .sign_o(sign_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; we_i = 1'b0; wa_i = '0; wd_i = '0;
    flag_we_i = 1'b0; zf_i = 1'b0; sign_i = 1'b0;
    ra1_i = 5'd3; ra2_i = 5'd31;
    for (int i = 0; i < 32; i++) model[i] = '0;
    step(); step();
    rst_i = 1'b0;
    step();
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); tests++;
    if (rd1_o !== e) begin fails++; $display("FAIL reset_rd1 got=%h exp=%h", rd1_o, e); end
    e = exp_q.pop_front(); tests++;
    if (rd2_o !== e) begin fails++; $display("FAIL reset_rd2 got=%h exp=%h", rd2_o, e); end
    e = exp_q.pop_front(); tests++;
    if ({31'h0, zf_o} !== e) begin fails++; $display("FAIL reset_zf got=%b exp=%h", zf_o, e); end
    e = exp_q.pop_front(); tests++;
    if ({31'h0, sign_o} !== e) begin fails++; $display("FAIL reset_sign got=%b exp=%h", sign_o, e); end
  endtask

  task automatic test_write();
    we_i = 1'b1; wa_i = 5'd5; wd_i = 32'hDEADBEEF; ra1_i = 5'd3;
    step();
    model[5] = 32'hDEADBEEF;
    we_i = 1'b0; ra1_i = 5'd5;
    exp_q.push_back(model[5]);
    #1;
    e = exp_q.pop_front(); tests++;
    if (rd1_o !== e) begin fails++; $display("FAIL write_r5 got=%h exp=%h", rd1_o, e); end
    wd_i = 32'h12345678;
    step();
    exp_q.push_back(model[5]);
    e = exp_q.pop_front(); tests++;
    if (rd1_o !== e) begin fails++; $display("FAIL write_we0_hold got=%h exp=%h", rd1_o, e); end
  endtask

  task automatic test_reg0();
    we_i = 1'b1; wa_i = 5'd0; wd_i = 32'hFFFFFFFF; ra1_i = 5'd0; ra2_i = 5'd0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); tests++;
    if (rd1_o !== e) begin fails++; $display("FAIL r0_bypass_rd1 got=%h exp=%h", rd1_o, e); end
    e = exp_q.pop_front(); tests++;
    if (rd2_o !== e) begin fails++; $display("FAIL r0_bypass_rd2 got=%h exp=%h", rd2_o, e); end
    step();
    we_i = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); tests++;
    if (rd1_o !== e) begin fails++; $display("FAIL r0_after_rd1 got=%h exp=%h", rd1_o, e); end
    e = exp_q.pop_front(); tests++;
    if (rd2_o !== e) begin fails++; $display("FAIL r0_after_rd2 got=%h exp=%h", rd2_o, e); end
  endtask

  task automatic test_bypass();
    we_i = 1'b1; wa_i = 5'd8; wd_i = 32'h11;
    step();
    model[8] = 32'h11;
    wa_i = 5'd7; wd_i = 32'hA5A5A5A5; ra1_i = 5'd7; ra2_i = 5'd7;
    exp_q.push_back(32'hA5A5A5A5); exp_q.push_back(32'hA5A5A5A5);
    #1;
    e = exp_q.pop_front(); tests++;
    if (rd1_o !== e) begin fails++; $display("FAIL bypass_both_rd1 got=%h exp=%h", rd1_o, e); end
    e = exp_q.pop_front(); tests++;
    if (rd2_o !== e) begin fails++; $display("FAIL bypass_both_rd2 got=%h exp=%h", rd2_o, e); end
    ra2_i = 5'd8;
    exp_q.push_back(32'hA5A5A5A5); exp_q.push_back(model[8]);
    #1;
    e = exp_q.pop_front(); tests++;
    if (rd1_o !== e) begin fails++; $display("FAIL bypass_one_rd1 got=%h exp=%h", rd1_o, e); end
    e = exp_q.pop_front(); tests++;
    if (rd2_o !== e) begin fails++; $display("FAIL bypass_one_rd2 got=%h exp=%h", rd2_o, e); end
    step();
    model[7] = 32'hA5A5A5A5;
    we_i = 1'b0; wd_i = 32'h0;
    exp_q.push_back(model[7]);
    #1;
    e = exp_q.pop_front(); tests++;
    if (rd1_o !== e) begin fails++; $display("FAIL bypass_commit got=%h exp=%h", rd1_o, e); end
  endtask

  task automatic test_flags();
    flag_we_i = 1'b1; zf_i = 1'b1; sign_i = 1'b0;
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); tests++;
    if ({31'h0, zf_o} !== e) begin fails++; $display("FAIL flag_no_bypass got=%b exp=%h", zf_o, e); end
    step();
    exp_q.push_back(32'h1); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); tests++;
    if ({31'h0, zf_o} !== e) begin fails++; $display("FAIL flag_set_zf got=%b exp=%h", zf_o, e); end
    e = exp_q.pop_front(); tests++;
    if ({31'h0, sign_o} !== e) begin fails++; $display("FAIL flag_set_sign got=%b exp=%h", sign_o, e); end
    flag_we_i = 1'b0; zf_i = 1'b0; sign_i = 1'b1;
    step();
    exp_q.push_back(32'h1); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); tests++;
    if ({31'h0, zf_o} !== e) begin fails++; $display("FAIL flag_hold_zf got=%b exp=%h", zf_o, e); end
    e = exp_q.pop_front(); tests++;
    if ({31'h0, sign_o} !== e) begin fails++; $display("FAIL flag_hold_sign got=%b exp=%h", sign_o, e); end
    // Register write and flag update in the same cycle.
    flag_we_i = 1'b1; we_i = 1'b1; wa_i = 5'd20; wd_i = 32'hCAFE0020; ra1_i = 5'd20;
    step();
    model[20] = 32'hCAFE0020;
    flag_we_i = 1'b0; we_i = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h1); exp_q.push_back(model[20]);
    #1;
    e = exp_q.pop_front(); tests++;
    if ({31'h0, zf_o} !== e) begin fails++; $display("FAIL flag_dual_zf got=%b exp=%h", zf_o, e); end
    e = exp_q.pop_front(); tests++;
    if ({31'h0, sign_o} !== e) begin fails++; $display("FAIL flag_dual_sign got=%b exp=%h", sign_o, e); end
    e = exp_q.pop_front(); tests++;
    if (rd1_o !== e) begin fails++; $display("FAIL flag_dual_reg got=%h exp=%h", rd1_o, e); end
  endtask

  task automatic test_back_to_back();
    we_i = 1'b1; wa_i = 5'd12; ra1_i = 5'd12; ra2_i = 5'd12;
    for (int i = 1; i <= 4; i++) begin
      wd_i = 32'h1000 + i;
      exp_q.push_back(32'h1000 + i);
      #1;
      e = exp_q.pop_front(); tests++;
      if (rd1_o !== e) begin fails++; $display("FAIL b2b_bypass[%0d] got=%h exp=%h", i, rd1_o, e); end
      step();
      model[12] = 32'h1000 + i;
    end
    we_i = 1'b0;
    exp_q.push_back(model[12]);
    #1;
    e = exp_q.pop_front(); tests++;
    if (rd2_o !== e) begin fails++; $display("FAIL b2b_final got=%h exp=%h", rd2_o, e); end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int n = 0; n < 60; n++) begin
      we_i  = 1'($urandom_range(0, 1));
      wa_i  = 5'($urandom_range(0, 31));
      wd_i  = $urandom;
      ra1_i = 5'($urandom_range(0, 31));
      ra2_i = (n % 4 == 0) ? wa_i : 5'($urandom_range(0, 31));
      e1 = model[ra1_i];
      e2 = model[ra2_i];
      if (we_i && wa_i != 0 && ra1_i == wa_i) e1 = wd_i;
      if (we_i && wa_i != 0 && ra2_i == wa_i) e2 = wd_i;
      if (ra1_i == 0) e1 = '0;
      if (ra2_i == 0) e2 = '0;
      exp_q.push_back(e1); exp_q.push_back(e2);
      #1;
      e = exp_q.pop_front(); tests++;
      if (rd1_o !== e) begin fails++; $display("FAIL rand_rd1[%0d] ra=%0d got=%h exp=%h", n, ra1_i, rd1_o, e); end
      e = exp_q.pop_front(); tests++;
      if (rd2_o !== e) begin fails++; $display("FAIL rand_rd2[%0d] ra=%0d got=%h exp=%h", n, ra2_i, rd2_o, e); end
      step();
      if (we_i && wa_i != 0) model[wa_i] = wd_i;
    end
    we_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    we_i = 1'b1; wa_i = 5'd9; wd_i = 32'h55;
    step();
    model[9] = 32'h55;
    we_i = 1'b0; ra1_i = 5'd9;
    exp_q.push_back(model[9]);
    #1;
    e = exp_q.pop_front(); tests++;
    if (rd1_o !== e) begin fails++; $display("FAIL rstmid_pre got=%h exp=%h", rd1_o, e); end
    #1;
    rst_i = 1'b1;
    we_i = 1'b1; wa_i = 5'd10; wd_i = 32'h77; ra2_i = 5'd10;
    flag_we_i = 1'b1; zf_i = 1'b1; sign_i = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = '0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); tests++;
    if (rd1_o !== e) begin fails++; $display("FAIL rstmid_async_rd1 got=%h exp=%h", rd1_o, e); end
    e = exp_q.pop_front(); tests++;
    if (rd2_o !== e) begin fails++; $display("FAIL rstmid_async_byp got=%h exp=%h", rd2_o, e); end
    step();
    rst_i = 1'b0; we_i = 1'b0; flag_we_i = 1'b0;
    ra1_i = 5'd10; ra2_i = 5'd9;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); tests++;
    if (rd1_o !== e) begin fails++; $display("FAIL rstmid_lost_write got=%h exp=%h", rd1_o, e); end
    e = exp_q.pop_front(); tests++;
    if (rd2_o !== e) begin fails++; $display("FAIL rstmid_r9 got=%h exp=%h", rd2_o, e); end
    e = exp_q.pop_front(); tests++;
    if ({30'h0, zf_o, sign_o} !== e) begin fails++; $display("FAIL rstmid_flags got=%b%b exp=%h", zf_o, sign_o, e); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_reg0();
    test_bypass();
    test_flags();
    test_back_to_back();
    test_random();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
